// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a 32-bit word stream into padded 512-bit SHA-256 blocks.
// Define SHA256_PAD_BYTESWAP_EN to accept little-endian input words.
module sha256_msg_padder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last
);
  typedef enum logic [1:0] {FILL, PAD, LEN, OUT} state_t;
  state_t             state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic [63:0]        cnt_q, cnt_d;
  logic [15:0][31:0]  buf_q, buf_d;
  logic               last_q, last_d;
  logic               pend_len_q, pend_len_d;
  logic               pend_80_q, pend_80_d;
  logic               run_q;
  logic [31:0]        word;
  logic [63:0]        bit_len;
  logic [4:0]         sh;
  logic               accept, fill15;
`ifdef SHA256_PAD_BYTESWAP_EN
  assign word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word = in_data;
`endif
  assign in_ready  = run_q & (state_q == FILL);
  assign accept    = in_valid & in_ready;
  assign blk_valid = state_q == OUT;
  assign blk_last  = last_q;
  assign blk_data  = buf_q;
  assign sh        = {in_bytes, 3'b000};
  assign bit_len   = {cnt_q[60:0], 3'b000};
  // The 0x80 word landing at 14/15 leaves no room for the length field
  assign fill15    = pend_len_q | (pend_80_q & (widx_q[3:1] == 3'b111));
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    last_d     = last_q;
    pend_len_d = pend_len_q;
    pend_80_d  = pend_80_q;
    case (state_q)
      FILL: if (accept) begin
        cnt_d  = cnt_q + ((in_last && in_bytes != 2'd0) ? {62'd0, in_bytes} : 64'd4);
        widx_d = widx_q + 4'd1;
        if (!in_last) begin
          buf_d[widx_q] = word;
          if (widx_q == 4'd15) state_d = OUT;
        end else if (in_bytes == 2'd0) begin
          buf_d[widx_q] = word;
          pend_80_d     = 1'b1;
          pend_len_d    = widx_q == 4'd15;
          state_d       = (widx_q == 4'd15) ? OUT : PAD;
        end else begin
          buf_d[widx_q] = (word & ~(32'hffff_ffff >> sh)) | (32'h8000_0000 >> sh);
          pend_len_d    = widx_q >= 4'd14;
          state_d       = (widx_q == 4'd15) ? OUT : (widx_q == 4'd13) ? LEN : PAD;
        end
      end
      PAD: begin
        buf_d[widx_q] = pend_80_q ? 32'h8000_0000 : 32'h0;
        pend_80_d     = 1'b0;
        widx_d        = widx_q + 4'd1;
        if (fill15) begin
          pend_len_d = 1'b1;
          if (widx_q == 4'd15) state_d = OUT;
        end else if (widx_q >= 4'd13) begin
          widx_d  = 4'd14;
          state_d = LEN;
        end
      end
      LEN: begin
        buf_d[widx_q] = widx_q[0] ? bit_len[31:0] : bit_len[63:32];
        widx_d        = widx_q + 4'd1;
        if (widx_q[0]) begin
          state_d = OUT;
          last_d  = 1'b1;
        end
      end
      OUT: if (blk_ready) begin
        widx_d = 4'd0;
        last_d = 1'b0;
        if (pend_len_q) begin
          pend_len_d = 1'b0;
          state_d    = PAD;
        end else begin
          state_d = FILL;
          if (last_q) cnt_d = 64'd0;
        end
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      widx_q     <= 4'd0;
      cnt_q      <= 64'd0;
      buf_q      <= '0;
      last_q     <= 1'b0;
      pend_len_q <= 1'b0;
      pend_80_q  <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
      pend_len_q <= pend_len_d;
      pend_80_q  <= pend_80_d;
      run_q      <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: random messages checked against a byte-level SHA-256 padding model.
module tb_sha256_msg_padder;
  logic         clk = 1'b0, reset_n = 1'b0;
  logic         in_valid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic [31:0]  in_data = '0;
  logic [1:0]   in_bytes = '0;
  logic         in_ready, blk_valid, blk_last;
  logic [511:0] blk_data, last_blk, abc_exp;
  logic [7:0]   msg[$];
  int           compared = 0, mismatched = 0;

  sha256_msg_padder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] drv(input logic [31:0] w);
`ifdef SHA256_PAD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic set_msg(input int n);
    msg.delete();
    repeat (n) msg.push_back(8'($urandom));
  endtask

  task automatic run_msg(input bit rnd, input string name);
    logic [7:0]   p[$];
    logic [511:0] eb[$];
    logic [511:0] e;
    logic [63:0]  bits;
    logic [31:0]  w;
    int n, nw, wi, bi, cyc;
    n = msg.size();
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int i = 0; i < 16; i++)
        e[32*i +: 32] = {p[64*b+4*i], p[64*b+4*i+1], p[64*b+4*i+2], p[64*b+4*i+3]};
      eb.push_back(e);
    end
    nw = (n + 3) / 4;
    wi = 0; bi = 0; cyc = 0;
    while (bi < eb.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      blk_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (blk_valid && blk_ready) begin
        compared++;
        if (blk_data !== eb[bi] || blk_last !== (bi == eb.size() - 1)) begin
          mismatched++;
          $display("FAIL %s blk%0d: got %h last=%b, want %h last=%b",
                   name, bi, blk_data, blk_last, eb[bi], bi == eb.size() - 1);
        end
        last_blk = blk_data;
        bi++;
      end
      if (wi < nw) begin
        w = $urandom;
        for (int j = 0; j < 4; j++)
          if (4*wi + j < n) w[31-8*j -: 8] = msg[4*wi+j];
        in_valid = rnd ? ($urandom_range(2) != 0) : 1'b1;
        in_data  = drv(w);
        in_last  = wi == nw - 1;
        in_bytes = in_last ? 2'(n % 4) : 2'($urandom);
        if (in_valid && in_ready) wi++;
      end else in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    compared++;
    if (bi != eb.size() || wi != nw) begin
      mismatched++;
      $display("FAIL %s progress: got blocks=%0d words=%0d, want blocks=%0d words=%0d",
               name, bi, wi, eb.size(), nw);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s idle: got blk_valid=%b in_ready=%b, want 0 1", name, blk_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_data !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got in_ready=%b blk_valid=%b blk_last=%b data=%h, want 0 0 0 0",
               in_ready, blk_valid, blk_last, blk_data);
    end
    reset_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: got in_ready=%b, want 0", in_ready);
    end
    @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic send_abc(input string name);
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, name);
    compared++;
    if (last_blk !== abc_exp) begin
      mismatched++;
      $display("FAIL %s const: got %h, want %h", name, last_blk, abc_exp);
    end
  endtask

  task automatic test_abc();
    send_abc("abc");
  endtask

  task automatic test_boundaries();
    int lens[12] = '{55, 56, 57, 59, 60, 61, 63, 64, 65, 119, 120, 128};
    foreach (lens[i]) begin
      set_msg(lens[i]);
      run_msg(1'b0, $sformatf("len%0d", lens[i]));
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] snap;
    int cyc;
    @(negedge clk);
    blk_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = drv(32'h6162_6300);
    in_last   = 1'b1;
    in_bytes  = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!blk_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    compared++;
    if (blk_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_wait: got blk_valid=%b, want 1", blk_valid);
    end
    snap = blk_data;
    for (int k = 0; k < 10; k++) begin
      compared++;
      if (blk_valid !== 1'b1 || blk_data !== snap || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got blk_valid=%b in_ready=%b data=%h, want 1 0 %h",
                 k, blk_valid, in_ready, blk_data, snap);
      end
      @(negedge clk);
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    compared++;
    if (blk_valid !== 1'b0 || snap !== abc_exp) begin
      mismatched++;
      $display("FAIL bp_xfer: got blk_valid=%b data=%h, want 0 %h", blk_valid, snap, abc_exp);
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    set_msg(40);
    while (cnt < 5) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = drv({msg[4*cnt], msg[4*cnt+1], msg[4*cnt+2], msg[4*cnt+3]});
      in_last  = 1'b0;
      if (in_ready) cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #2;
    compared++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got in_ready=%b blk_valid=%b, want 0 0", in_ready, blk_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_abc("abc_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      set_msg($urandom_range(150, 1));
      run_msg(1'b1, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    abc_exp          = '0;
    abc_exp[31:0]    = 32'h6162_6380;
    abc_exp[511:480] = 32'h0000_0018;
    test_reset();
    test_abc();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
